multicycle_main_control: RTL
============================

// Module: multicycle_main_control
// PURPOSE
//  Main sequencing FSM for the multicycle MIPS datapath. Decodes the IR opcode and steps the shared ALU, memory,
//  IR, PC and register file through fetch/decode/execute/memory/writeback. Drives the 2-bit alu_op consumed by the
//  ALU control decoder. Stalls on a single-signal memory ready handshake. Counts retired instructions.
// PARAMETERS
//  CNT_W      32   width of retired-instruction counter (wraps modulo 2^CNT_W)
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  opcode         in   6      IR[31:26], valid from DECODE onward
//  zero           in   1      ALU zero flag
//  mem_ready      in   1      memory completes current read/write this cycle
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load if zero
//  iord           out  1      0=PC addresses memory, 1=ALUOut
//  mem_read       out  1      memory read request
//  mem_write      out  1      memory write request
//  ir_write       out  1      latch instruction register
//  reg_dst        out  1      0=rt, 1=rd
//  mem_to_reg     out  1      0=ALUOut, 1=MDR
//  reg_write      out  1      register file write
//  alu_src_a      out  1      0=PC, 1=rs
//  alu_src_b      out  2      00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op         out  2      00=funct-decoded, 01=subtract, 10=add; 11 never driven
//  pc_src         out  2      00=ALU result, 01=ALUOut, 10=jump target
//  illegal_op     out  1      one-cycle pulse, unsupported opcode in DECODE
//  instr_count    out  CNT_W  retired instructions
//  state_dbg      out  4      current state encoding
// BEHAVIOUR
//  States (4-bit encoding): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 REX=6 RWB=7 BEQ=8 ADDIEX=9
//  ADDIWB=10 JMP=11. Encodings 12-15 are unreachable and go to FETCH.
//  Outputs are Moore (decoded from registered state only). Every output not listed for a state is 0.
//  FETCH: mem_read, alu_src_b=01, alu_op=10.
//   - With mem_ready=1: also ir_write and pc_write; next state DECODE.
//   - With mem_ready=0: ir_write/pc_write=0; stay in FETCH.
//  DECODE: alu_src_b=11, alu_op=10. Next state by opcode:
//   - 0x23/0x2B -> MEMADR; 0x00 -> REX; 0x04 -> BEQ; 0x08 -> ADDIEX; 0x02 -> JMP.
//   - Any other opcode -> FETCH, with illegal_op=1 for this cycle; instr_count unchanged.
//  MEMADR: alu_src_a=1, alu_src_b=10, alu_op=10. opcode 0x23 -> MEMRD, otherwise -> MEMWR.
//  MEMRD: mem_read, iord. Stays until mem_ready, then MEMWB.
//  MEMWR: mem_write, iord. Stays until mem_ready, then FETCH (retire).
//  MEMWB: reg_write, mem_to_reg. Next FETCH (retire).
//  REX: alu_src_a=1, alu_src_b=00, alu_op=00 -> RWB.
//  RWB: reg_write, reg_dst -> FETCH (retire).
//  BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond, pc_src=01 -> FETCH (retire).
//  ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=10 -> ADDIWB.
//  ADDIWB: reg_write -> FETCH (retire).
//  JMP: pc_write, pc_src=10 -> FETCH (retire).
//  Retire: instr_count += 1 on the edge leaving MEMWR(ready), MEMWB, RWB, BEQ, ADDIWB or JMP.
//  The count wraps from all-ones to 0.
//  mem_read/mem_write stay asserted and iord stays stable for the whole stall; address is held by datapath.
//  Reset: on any edge with reset=1, state<=FETCH and instr_count<=0, overriding any transition or retire.
//   - Mid-stall or mid-instruction reset abandons the instruction; it is not counted.
//   - While reset=1 all strobes (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_op)
//     are forced 0. Mux selects are don't-care but must equal the FETCH values.
//  Cycle counts with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
// TESTING
//  1 reset 2 cycles, mem_ready=1, opcode=0x00 -> states 0,1,6,7,0. RWB has reg_write=1, reg_dst=1.
//    REX has alu_op=00. instr_count=1 after 4 cycles.
//  2 opcode=0x23, mem_ready low for 3 cycles in MEMRD -> state_dbg holds 3 with mem_read=iord=1.
//    Then MEMWB with mem_to_reg=1. Total 8 cycles, count +1.
//  3 opcode=0x04, zero=1 -> BEQ cycle drives alu_op=01, pc_write_cond=1, pc_src=01.
//    opcode=0x02 -> JMP drives pc_write=1, pc_src=10.
//  4 opcode=0x3F in DECODE -> illegal_op=1 for exactly 1 cycle, next state FETCH, instr_count unchanged.
//  5 reset asserted in MEMWR with mem_ready=0 -> next state FETCH, instr_count=0, mem_write=0 during reset cycle.
//  6 CNT_W=4, retire 17 j instructions -> instr_count=1 (wrap). FETCH stall: mem_ready=0 5 cycles ->
//    ir_write/pc_write stay 0.

Source files
------------

// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multicycle MIPS sequencer and its datapath.
// master: sequencer side (drives control strobes/selects, reads opcode and memory ready).
// slave:  datapath side (drives opcode/zero/mem_ready, consumes controls and debug state).
interface multicycle_main_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_src;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, instr_count, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, illegal_op, instr_count, state_dbg
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main sequencing FSM of the multicycle MIPS datapath; counts retired instructions.
// Latency: 3-5 cycles per instruction (lw 5, sw/R/addi 4, beq/j 3) plus memory stall cycles.
// Backpressure: stalls in FETCH/MEMRD/MEMWR until mem_ready, holding mem_read/mem_write/iord steady.
// Ports: clk, reset (sync, active-high); bus (master modport): opcode/zero/mem_ready in,
//        datapath strobes + mux selects, illegal_op pulse, instr_count, state_dbg out.
module multicycle_main_control #(
  parameter int CNT_W = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_main_control_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JMP    = 4'd11
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] instr_count;
  logic             legal_op;

  // Branch resolution happens in the datapath via pc_write_cond, so zero is not needed here.
  wire unused_zero = bus.zero;

  always_comb begin
    legal_op = 1'b0;
    case (bus.opcode)
      6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02: legal_op = 1'b1;
      default:                                  legal_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      instr_count <= '0;
    end else begin
      case (state)
        FETCH:  if (bus.mem_ready) state <= DECODE;
        DECODE: begin
          case (bus.opcode)
            6'h23, 6'h2B: state <= MEMADR;
            6'h00:        state <= REX;
            6'h04:        state <= BEQ;
            6'h08:        state <= ADDIEX;
            6'h02:        state <= JMP;
            default:      state <= FETCH;
          endcase
        end
        MEMADR: state <= (bus.opcode == 6'h23) ? MEMRD : MEMWR;
        MEMRD:  if (bus.mem_ready) state <= MEMWB;
        MEMWR: begin
          if (bus.mem_ready) begin
            state       <= FETCH;
            instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        REX:    state <= RWB;
        ADDIEX: state <= ADDIWB;
        MEMWB, RWB, BEQ, ADDIWB, JMP: begin
          state       <= FETCH;
          instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs follow the registered state; FETCH's IR/PC load waits for mem_ready,
  // and an asserted reset masks every strobe so nothing commits during that edge.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_src        = 2'b00;
    bus.illegal_op    = 1'b0;
    if (reset) begin
      bus.alu_src_b = 2'b01;
      bus.alu_op    = 2'b10;
    end else begin
      case (state)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.alu_op    = 2'b10;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_b  = 2'b11;
          bus.alu_op     = 2'b10;
          bus.illegal_op = ~legal_op;
        end
        MEMADR, ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = 2'b10;
        end
        MEMRD: begin
          bus.mem_read = 1'b1;
          bus.iord     = 1'b1;
        end
        MEMWR: begin
          bus.mem_write = 1'b1;
          bus.iord      = 1'b1;
        end
        MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        REX: bus.alu_src_a = 1'b1;
        RWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 1'b1;
        end
        BEQ: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.pc_src        = 2'b01;
        end
        ADDIWB: bus.reg_write = 1'b1;
        JMP: begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign bus.instr_count = instr_count;
  assign bus.state_dbg   = state;

endmodule
